// File: rtl/seg_scan4_pkg.sv
// Shared display constants and types for the 4-digit scan driver and the BCD stage.
package seg_scan4_pkg;

   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam logic [3:0] AN_OFF  = 4'b1111;

   typedef logic [1:0] slot_idx_t;

   // Slot ordering shared with the BCD converter outputs.
   localparam slot_idx_t SLOT_ONES      = 2'd0;
   localparam slot_idx_t SLOT_TENS      = 2'd1;
   localparam slot_idx_t SLOT_HUNDREDS  = 2'd2;
   localparam slot_idx_t SLOT_THOUSANDS = 2'd3;

   typedef struct packed {
      logic [3:0][3:0] digit;
      logic [3:0]      dp_mask;
   } snapshot_t;

endpackage

// File: rtl/seg_scan4_if.sv
// Digit inputs and display pin outputs of the scan driver.
interface seg_scan4_if;
   import seg_scan4_pkg::*;

   logic       en;
   logic [3:0] thousands;
   logic [3:0] hundreds;
   logic [3:0] tens;
   logic [3:0] ones;
   logic [3:0] dp_mask;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   slot_idx_t  digit_idx;

   modport master (
      output en, thousands, hundreds, tens, ones, dp_mask,
      input  an, seg, dp, digit_idx
   );

   modport slave (
      input  en, thousands, hundreds, tens, ones, dp_mask,
      output an, seg, dp, digit_idx
   );

endinterface

// File: rtl/sevenseg_hex_ca.sv
// Hex digit to active-low common-anode segments {g,f,e,d,c,b,a}; blank forces all off.
module sevenseg_hex_ca
   import seg_scan4_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_OFF;
      if (!blank_i) begin
         unique case (digit_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'ha: seg_o = 7'b0001000;
            4'hb: seg_o = 7'b0000011;
            4'hc: seg_o = 7'b1000110;
            4'hd: seg_o = 7'b0100001;
            4'he: seg_o = 7'b0000110;
            4'hf: seg_o = 7'b0001110;
         endcase
      end
   end

endmodule

// File: rtl/seg_scan4.sv
// Time-multiplexed 4-digit common-anode scan driver with dead time and per-frame digit capture.
// Define SEG_SCAN4_LZB_EN to blank leading zeros in slots 3..1.
module seg_scan4
   import seg_scan4_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned DEAD_CYC    = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   seg_scan4_if.slave bus
);

   if (REFRESH_DIV < 2 || DEAD_CYC >= REFRESH_DIV) begin : g_bad_param
      $error("seg_scan4: need REFRESH_DIV >= 2 and DEAD_CYC < REFRESH_DIV");
   end

   localparam int unsigned CntW = (REFRESH_DIV < 2) ? 1 : $clog2(REFRESH_DIV);
   localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);

   logic [CntW-1:0] cnt_q;
   slot_idx_t       idx_q;
   snapshot_t       snap_q, snap_d;
   logic [3:0]      an_q;
   logic [6:0]      seg_q;
   logic            dp_q;

   logic            last, dead, lzb_blank, snap_load;
   logic [3:0]      an_dec;
   logic [6:0]      seg_dec;
   logic            dp_dec;

   assign last = (cnt_q == CntLast);

   if (DEAD_CYC == 0) begin : g_no_dead
      assign dead = 1'b0;
   end else begin : g_dead
      assign dead = (cnt_q < CntW'(DEAD_CYC));
   end

`ifdef SEG_SCAN4_LZB_EN
   logic z3, z2, z1;
   always_comb begin
      z3 = (snap_q.digit[SLOT_THOUSANDS] == 4'h0);
      z2 = z3 && (snap_q.digit[SLOT_HUNDREDS] == 4'h0);
      z1 = z2 && (snap_q.digit[SLOT_TENS] == 4'h0);
      lzb_blank = 1'b0;
      unique case (idx_q)
         SLOT_THOUSANDS: lzb_blank = z3;
         SLOT_HUNDREDS:  lzb_blank = z2;
         SLOT_TENS:      lzb_blank = z1;
         SLOT_ONES:      lzb_blank = 1'b0;
      endcase
   end
`else
   assign lzb_blank = 1'b0;
`endif

   sevenseg_hex_ca u_enc (
      .digit_i (snap_q.digit[idx_q]),
      .blank_i (dead | lzb_blank),
      .seg_o   (seg_dec)
   );

   // A blanked (LZB) slot keeps its anode and decimal point; only dead time turns them off.
   assign an_dec = dead ? AN_OFF : ~(4'b0001 << idx_q);
   assign dp_dec = dead | ~snap_q.dp_mask[idx_q];

   // Capture only at the frame boundary so a frame never mixes old and new digits.
   assign snap_load = !bus.en || (last && (idx_q == SLOT_THOUSANDS));

   always_comb begin
      snap_d                       = snap_q;
      snap_d.digit[SLOT_THOUSANDS] = bus.thousands;
      snap_d.digit[SLOT_HUNDREDS]  = bus.hundreds;
      snap_d.digit[SLOT_TENS]      = bus.tens;
      snap_d.digit[SLOT_ONES]      = bus.ones;
      snap_d.dp_mask               = bus.dp_mask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         idx_q  <= SLOT_ONES;
         snap_q <= '0;
         an_q   <= AN_OFF;
         seg_q  <= SEG_OFF;
         dp_q   <= 1'b1;
      end else begin
         if (bus.en) begin
            if (last) begin
               cnt_q <= '0;
               idx_q <= idx_q + slot_idx_t'(1);
            end else begin
               cnt_q <= cnt_q + CntW'(1);
            end
            an_q  <= an_dec;
            seg_q <= seg_dec;
            dp_q  <= dp_dec;
         end else begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
         end
         if (snap_load) begin
            snap_q <= snap_d;
         end
      end
   end

   assign bus.an        = an_q;
   assign bus.seg       = seg_q;
   assign bus.dp        = dp_q;
   assign bus.digit_idx = idx_q;

endmodule
